sequence_blinker: RTL

SEQUENCE_BLINKER -- requirements
Module: sequence_blinker

---
 rtl/sequence_blinker.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sequence_blinker.sv
// Plays the first `level` colours of the sequence memory on one-hot LEDs,
// one step at a time, then pulses blinker_done once per request.
module sequence_blinker #(
   parameter int ON_CYCLES  = 25000000,
   parameter int OFF_CYCLES = 12500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       on_blinker,
   input  logic [3:0] level,
   output logic       rd_en,
   output logic [3:0] rd_addr,
   input  logic [1:0] rd_data,
   output logic [3:0] led,
   output logic       blinker_done
);

   localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
   localparam logic [3:0]    MAX_STEPS = 4'd10;

   typedef enum logic [2:0] {
      IDLE, FETCH, WAIT_DATA, ON, OFF, DONE, REARM
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    idx_q, idx_d;
   logic [3:0]    lvl_q, lvl_d;
   logic [1:0]    colour_q, colour_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          rd_en_q, rd_en_d;
   logic [3:0]    rd_addr_q, rd_addr_d;
   logic [3:0]    led_q, led_d;
   logic          done_q, done_d;

   // NOTE: every output is a register loaded together with the state it belongs to.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         lvl_q     <= '0;
         colour_q  <= '0;
         timer_q   <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         led_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         lvl_q     <= lvl_d;
         colour_q  <= colour_d;
         timer_q   <= timer_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         led_q     <= led_d;
         done_q    <= done_d;
      end
   end

   // NOTE: defaults first so no path leaves a variable unassigned (no latches).
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      lvl_d     = lvl_q;
      colour_d  = colour_q;
      timer_d   = timer_q;
      rd_en_d   = 1'b0;
      rd_addr_d = '0;
      led_d     = '0;
      done_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            timer_d = '0;
            if (on_blinker) begin
               idx_d = '0;
               lvl_d = (level > MAX_STEPS) ? MAX_STEPS : level;
               if (level == 4'd0) begin
                  state_d = DONE;
               end else begin
                  // The start cycle doubles as the first address cycle.
                  rd_en_d = 1'b1;
                  state_d = FETCH;
               end
            end
         end
         FETCH: begin
            if (!on_blinker) begin
               state_d = IDLE;
            end else if (rd_en_q) begin
               state_d = WAIT_DATA;
            end else begin
               // Between steps FETCH first spends a setup cycle issuing the read.
               rd_en_d   = 1'b1;
               rd_addr_d = idx_q;
            end
         end
         WAIT_DATA: begin
            if (!on_blinker) begin
               state_d = IDLE;
            end else begin
               colour_d = rd_data;
               timer_d  = ON_LOAD;
               led_d    = 4'b0001 << rd_data;
               state_d  = ON;
            end
         end
         ON: begin
            if (!on_blinker) begin
               state_d = IDLE;
            end else if (timer_q == '0) begin
               timer_d = OFF_LOAD;
               state_d = OFF;
            end else begin
               timer_d = timer_q - TW'(1);
               led_d   = 4'b0001 << colour_q;
            end
         end
         OFF: begin
            if (!on_blinker) begin
               state_d = IDLE;
            end else if (timer_q != '0) begin
               timer_d = timer_q - TW'(1);
            end else if (idx_q + 4'd1 < lvl_q) begin
               idx_d   = idx_q + 4'd1;
               state_d = FETCH;
            end else begin
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            // Entered either with the pulse already raised or, for level 0, without it.
            if (done_q) begin
               state_d = REARM;
            end else begin
               done_d = 1'b1;
            end
         end
         REARM: begin
            if (!on_blinker) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign rd_en        = rd_en_q;
   assign rd_addr      = rd_addr_q;
   assign led          = led_q;
   assign blinker_done = done_q;

endmodule
